// File: rtl/qbert_pio_pkg.sv
// Shared register map and edge-select encodings for the qbert input PIO.
package qbert_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_RAW      = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // True when a transition to new_level should be captured for the given edge type.
  function automatic logic edge_hit(input int edge_type, input logic new_level);
    logic hit;
    case (edge_type)
      EDGE_RISING:  hit = new_level;
      EDGE_FALLING: hit = ~new_level;
      default:      hit = 1'b1;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/qbert_pio_in_irq_if.sv
// Avalon-MM slave bus bundle for the qbert input PIO, including its interrupt line.
interface qbert_pio_in_irq_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata,
    input  irq
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata,
    output irq
  );

endinterface

// File: rtl/qbert_pio_debounce_bit.sv
// One input bit: synchroniser chain, consecutive-stable debounce counter and edge pulse.
module qbert_pio_debounce_bit
  import qbert_pio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = EDGE_RISING
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  output logic raw_o,
  output logic stable_o,
  output logic edge_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   raw;
  logic                   edge_pulse;

  assign raw = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], pin_i};
    stable_d   = stable_q;
    cnt_d      = '0;
    edge_pulse = 1'b0;
    // Any cycle where raw agrees with stable restarts the count, so short glitches never land.
    if (raw != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d   = raw;
        cnt_d      = '0;
        edge_pulse = edge_hit(EDGE_TYPE, raw);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign raw_o    = raw;
  assign stable_o = stable_q;
  assign edge_o   = edge_pulse;

endmodule

// File: rtl/qbert_pio_in_irq.sv
// Parametrised Avalon-MM input PIO: per-bit debounce, sticky edge capture, interrupt mask and registered IRQ.
module qbert_pio_in_irq
  import qbert_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = EDGE_RISING
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   in_port,
  qbert_pio_in_irq_if.slave  bus
);

  logic [WIDTH-1:0] raw_vec;
  logic [WIDTH-1:0] stable_vec;
  logic [WIDTH-1:0] edge_vec;

  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             wr_en;
  logic [WIDTH-1:0] wr_bits;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    qbert_pio_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .EDGE_TYPE       (EDGE_TYPE)
    ) u_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .pin_i    (in_port[i]),
      .raw_o    (raw_vec[i]),
      .stable_o (stable_vec[i]),
      .edge_o   (edge_vec[i])
    );
  end

  if (WIDTH < 32) begin : g_wd_unused
    logic unused_wd;
    assign unused_wd = ^bus.writedata[31:WIDTH];
  end

  assign wr_en   = bus.chipselect & ~bus.write_n;
  assign wr_bits = bus.writedata[WIDTH-1:0];

  always_comb begin
    irq_mask_d = irq_mask_q;
    edgecap_d  = edgecap_q;
    if (wr_en && (bus.address == ADDR_IRQ_MASK)) begin
      irq_mask_d = wr_bits;
    end
    if (wr_en && (bus.address == ADDR_EDGECAP)) begin
      edgecap_d = edgecap_d & ~wr_bits;
    end
    // Set is applied after the clear so a fresh capture survives a same-cycle clear.
    edgecap_d = edgecap_d | edge_vec;
    irq_d     = |(edgecap_d & irq_mask_d);
  end

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_DATA:     readdata_d = 32'(stable_vec);
      ADDR_RAW:      readdata_d = 32'(raw_vec);
      ADDR_IRQ_MASK: readdata_d = 32'(irq_mask_q);
      ADDR_EDGECAP:  readdata_d = 32'(edgecap_q);
      default:       readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_q <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_qbert_pio_in_irq.sv
// Directed bench for qbert_pio_in_irq: one rising-edge instance plus falling/any-edge instances on the same pins.
module tb_qbert_pio_in_irq;
  import qbert_pio_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [3:0] in_port;

  int total_cnt = 0;
  int fail_cnt  = 0;

  qbert_pio_in_irq_if bus0 ();
  qbert_pio_in_irq_if busf ();
  qbert_pio_in_irq_if busa ();

  qbert_pio_in_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(EDGE_RISING)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus0));
  qbert_pio_in_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(EDGE_FALLING)) dutf (
    .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(busf));
  qbert_pio_in_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(EDGE_ANY)) duta (
    .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(busa));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp)
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input logic [1:0] a);
    bus0.address = a;
    busf.address = a;
    busa.address = a;
  endtask

  task automatic bus_idle();
    bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.writedata = '0;
    busf.chipselect = 1'b0; busf.write_n = 1'b1; busf.writedata = '0;
    busa.chipselect = 1'b0; busa.write_n = 1'b1; busa.writedata = '0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    set_addr(a);
    bus0.chipselect = 1'b1; bus0.write_n = 1'b0; bus0.writedata = d;
    busf.chipselect = 1'b1; busf.write_n = 1'b0; busf.writedata = d;
    busa.chipselect = 1'b1; busa.write_n = 1'b0; busa.writedata = d;
    tick();
    bus_idle();
  endtask

  task automatic rd(input logic [1:0] a);
    set_addr(a);
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    in_port = 4'h0;
    bus_idle();
    set_addr(ADDR_DATA);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Reset in the middle of operation with all inputs high
    wr(ADDR_IRQ_MASK, 32'hF);
    in_port = 4'hF;
    repeat (10) tick();
    rd(ADDR_DATA);
    chk("pre_reset_data", bus0.readdata, 32'hF);
    chk("pre_reset_irq", 32'(bus0.irq), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_readdata", bus0.readdata, 32'h0);
    chk("async_reset_irq", 32'(bus0.irq), 32'd0);
    in_port = 4'h0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    rd(ADDR_DATA);     chk("post_reset_data", bus0.readdata, 32'h0);
    rd(ADDR_RAW);      chk("post_reset_raw", bus0.readdata, 32'h0);
    rd(ADDR_IRQ_MASK); chk("post_reset_mask", bus0.readdata, 32'h0);
    rd(ADDR_EDGECAP);  chk("post_reset_edgecap", bus0.readdata, 32'h0);
    chk("post_reset_irq", 32'(bus0.irq), 32'd0);

    // Sync and debounce latency boundaries for 0 -> 5
    in_port = 4'h5;
    set_addr(ADDR_RAW);
    tick(); tick();
    chk("raw_edge2", bus0.readdata, 32'h0);
    tick();
    chk("raw_edge3", bus0.readdata, 32'h5);
    set_addr(ADDR_DATA);
    tick(); tick(); tick();
    chk("data_edge6", bus0.readdata, 32'h0);
    tick();
    chk("data_edge7", bus0.readdata, 32'h5);
    rd(ADDR_EDGECAP);
    chk("edgecap_rise_5", bus0.readdata, 32'h5);
    chk("irq_masked_off", 32'(bus0.irq), 32'd0);
    wr(ADDR_EDGECAP, 32'hF);
    rd(ADDR_EDGECAP);
    chk("edgecap_cleared", bus0.readdata, 32'h0);
    in_port = 4'h0;
    repeat (10) tick();
    rd(ADDR_EDGECAP);
    chk("edgecap_fall_ignored", bus0.readdata, 32'h0);

    // 3-cycle glitch rejected, 4-cycle pulse accepted
    set_addr(ADDR_DATA);
    in_port = 4'h1;
    repeat (3) tick();
    in_port = 4'h0;
    repeat (10) tick();
    rd(ADDR_DATA);    chk("glitch_data", bus0.readdata, 32'h0);
    rd(ADDR_EDGECAP); chk("glitch_edgecap", bus0.readdata, 32'h0);
    set_addr(ADDR_DATA);
    in_port = 4'h1;
    repeat (4) tick();
    in_port = 4'h0;
    repeat (3) tick();
    chk("pulse_data", bus0.readdata, 32'h1);
    repeat (10) tick();
    rd(ADDR_EDGECAP); chk("pulse_edgecap", bus0.readdata, 32'h1);
    rd(ADDR_DATA);    chk("pulse_data_back", bus0.readdata, 32'h0);
    wr(ADDR_EDGECAP, 32'hF);

    // Interrupt mask, capture timing and clearing
    wr(ADDR_IRQ_MASK, 32'h1);
    in_port = 4'h1;
    repeat (5) tick();
    chk("irq_before_capture", 32'(bus0.irq), 32'd0);
    tick();
    chk("irq_at_capture", 32'(bus0.irq), 32'd1);
    wr(ADDR_EDGECAP, 32'h1);
    chk("irq_after_clear", 32'(bus0.irq), 32'd0);
    in_port = 4'h3;
    repeat (10) tick();
    rd(ADDR_EDGECAP);
    chk("edgecap_masked_bit1", bus0.readdata, 32'h2);
    chk("irq_masked_bit1", 32'(bus0.irq), 32'd0);
    wr(ADDR_IRQ_MASK, 32'h3);
    chk("irq_unmask", 32'(bus0.irq), 32'd1);
    wr(ADDR_IRQ_MASK, 32'h1);
    chk("irq_remask", 32'(bus0.irq), 32'd0);
    wr(ADDR_EDGECAP, 32'hF);
    in_port = 4'h0;
    repeat (10) tick();
    wr(ADDR_IRQ_MASK, 32'h0);

    // Clear and capture of bit 2 on the same edge: capture wins
    in_port = 4'h4;
    repeat (5) tick();
    wr(ADDR_EDGECAP, 32'h4);
    rd(ADDR_EDGECAP);
    chk("set_wins_over_clear", bus0.readdata, 32'h4);
    wr(ADDR_EDGECAP, 32'h4);
    rd(ADDR_EDGECAP);
    chk("later_clear", bus0.readdata, 32'h0);

    // Edge type comparison across the three instances
    in_port = 4'h0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    in_port = 4'h1;
    repeat (10) tick();
    rd(ADDR_EDGECAP);
    chk("rise_type_rising", bus0.readdata, 32'h1);
    chk("rise_type_falling", busf.readdata, 32'h0);
    chk("rise_type_any", busa.readdata, 32'h1);
    wr(ADDR_EDGECAP, 32'hF);
    in_port = 4'h0;
    repeat (10) tick();
    rd(ADDR_EDGECAP);
    chk("fall_type_rising", bus0.readdata, 32'h0);
    chk("fall_type_falling", busf.readdata, 32'h1);
    chk("fall_type_any", busa.readdata, 32'h1);

    $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
    $finish;
  end

endmodule
